// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - CPU, DMA and data-memory port bundle for dmem_arbiter
interface dmem_arbiter_if #(
  parameter int DW = 24
);
  logic          cpu_req;
  logic          cpu_we;
  logic [DW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_stall;
  logic          cpu_rvalid;
  logic [DW-1:0] cpu_rdata;

  logic          dma_req;
  logic          dma_we;
  logic [DW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata;
  logic          dma_gnt;
  logic          dma_rvalid;
  logic [DW-1:0] dma_rdata;

  logic [DW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic          mem_re;
  logic [DW-1:0] mem_rdata;

  // Environment side: requesters plus the memory read-data return
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output dma_req, dma_we, dma_addr, dma_wdata,
    output mem_rdata,
    input  cpu_stall, cpu_rvalid, cpu_rdata,
    input  dma_gnt, dma_rvalid, dma_rdata,
    input  mem_addr, mem_wdata, mem_we, mem_re
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    input  mem_rdata,
    output cpu_stall, cpu_rvalid, cpu_rdata,
    output dma_gnt, dma_rvalid, dma_rdata,
    output mem_addr, mem_wdata, mem_we, mem_re
  );
endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - CPU/DMA data-memory arbiter with DMA starvation guard
module dmem_arbiter #(
  parameter int DW         = 24,
  parameter int STARVE_MAX = 4
) (
  input  logic           clk,
  input  logic           reset,
  dmem_arbiter_if.slave  bus
);
  localparam logic [1:0] RD_NONE = 2'd0;
  localparam logic [1:0] RD_CPU  = 2'd1;
  localparam logic [1:0] RD_DMA  = 2'd2;
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0] starve_q, starve_d;
  logic [1:0] rd_owner_q, rd_owner_d;
  logic       cpu_gnt, dma_gnt;

  // CPU owns the port unless the DMA has been refused STARVE_MAX cycles in a row
  always_comb begin
    dma_gnt = bus.dma_req & (~bus.cpu_req | (starve_q == STARVE_LIM));
    cpu_gnt = bus.cpu_req & ~dma_gnt;
  end

  always_comb begin
    starve_d = 4'd0;
    if (bus.dma_req && !dma_gnt) begin
      starve_d = (starve_q == STARVE_LIM) ? STARVE_LIM : starve_q + 4'd1;
    end
  end

  always_comb begin
    rd_owner_d = RD_NONE;
    if (dma_gnt && !bus.dma_we) begin
      rd_owner_d = RD_DMA;
    end else if (cpu_gnt && !bus.cpu_we) begin
      rd_owner_d = RD_CPU;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_q   <= 4'd0;
      rd_owner_q <= RD_NONE;
    end else begin
      starve_q   <= starve_d;
      rd_owner_q <= rd_owner_d;
    end
  end

  assign bus.mem_addr  = cpu_gnt ? bus.cpu_addr  : (dma_gnt ? bus.dma_addr  : {DW{1'b0}});
  assign bus.mem_wdata = cpu_gnt ? bus.cpu_wdata : (dma_gnt ? bus.dma_wdata : {DW{1'b0}});
  assign bus.mem_we    = (cpu_gnt & bus.cpu_we)  | (dma_gnt & bus.dma_we);
  assign bus.mem_re    = (cpu_gnt & ~bus.cpu_we) | (dma_gnt & ~bus.dma_we);

  assign bus.cpu_stall = bus.cpu_req & ~cpu_gnt;
  assign bus.dma_gnt   = dma_gnt;

  // Read data is steered by who issued the read one cycle earlier
  assign bus.cpu_rvalid = (rd_owner_q == RD_CPU);
  assign bus.dma_rvalid = (rd_owner_q == RD_DMA);
  assign bus.cpu_rdata  = bus.cpu_rvalid ? bus.mem_rdata : {DW{1'b0}};
  assign bus.dma_rdata  = bus.dma_rvalid ? bus.mem_rdata : {DW{1'b0}};
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter
module tb_dmem_arbiter;
  localparam int DW = 24;
  localparam int SM = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.DW(DW)) bus ();
  dmem_arbiter #(.DW(DW), .STARVE_MAX(SM)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Behavioural memory attached to the DUT's memory port
  logic [DW-1:0] tbmem [256];
  logic [DW-1:0] shadow [256];
  logic          cap_re = 1'b0, cap_we = 1'b0;
  logic [7:0]    cap_a = 8'd0;
  logic [DW-1:0] cap_wd = '0;

  initial begin
    for (int i = 0; i < 256; i++) begin
      tbmem[i]  = 24'h5A0000 + DW'(i);
      shadow[i] = 24'h5A0000 + DW'(i);
    end
    bus.mem_rdata = '0;
  end

  always @(negedge clk) begin
    cap_re = bus.mem_re;
    cap_we = bus.mem_we;
    cap_a  = bus.mem_addr[7:0];
    cap_wd = bus.mem_wdata;
  end

  always @(posedge clk) begin
    if (cap_we) tbmem[cap_a] = cap_wd;
    bus.mem_rdata = cap_re ? tbmem[cap_a] : DW'($urandom);
  end

  // Model state: run of consecutive refused DMA cycles and the pending read return
  int            run = 0, nx_run = 0;
  int            own = 0, nx_own = 0;
  logic [DW-1:0] odata = '0, nx_data = '0;
  logic          e_dma, e_cpu;
  logic [DW-1:0] ea, ew;

  always @(negedge clk) begin
    e_dma = bus.dma_req && (!bus.cpu_req || run >= SM);
    e_cpu = bus.cpu_req && !e_dma;
    ea = e_cpu ? bus.cpu_addr  : (e_dma ? bus.dma_addr  : '0);
    ew = e_cpu ? bus.cpu_wdata : (e_dma ? bus.dma_wdata : '0);
    chk("cpu_stall", bus.cpu_stall, bus.cpu_req && !e_cpu);
    chk("dma_gnt", bus.dma_gnt, e_dma);
    chk("mem_we", bus.mem_we, (e_cpu && bus.cpu_we) || (e_dma && bus.dma_we));
    chk("mem_re", bus.mem_re, (e_cpu && !bus.cpu_we) || (e_dma && !bus.dma_we));
    chk("mem_addr", bus.mem_addr, ea);
    chk("mem_wdata", bus.mem_wdata, ew);
    chk("cpu_rvalid", bus.cpu_rvalid, own == 1);
    chk("dma_rvalid", bus.dma_rvalid, own == 2);
    chk("cpu_rdata", bus.cpu_rdata, (own == 1) ? odata : '0);
    chk("dma_rdata", bus.dma_rdata, (own == 2) ? odata : '0);
    if (bus.mem_we === 1'b1 || (e_cpu && bus.cpu_we) || (e_dma && bus.dma_we)) begin
      if ((e_cpu && bus.cpu_we) || (e_dma && bus.dma_we)) shadow[ea[7:0]] = ew;
    end
    nx_run = (bus.dma_req && !e_dma) ? run + 1 : 0;
    if (e_dma && !bus.dma_we) begin
      nx_own = 2; nx_data = shadow[ea[7:0]];
    end else if (e_cpu && !bus.cpu_we) begin
      nx_own = 1; nx_data = shadow[ea[7:0]];
    end else begin
      nx_own = 0; nx_data = '0;
    end
  end

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      run = 0; own = 0;
    end else begin
      run = nx_run; own = nx_own; odata = nx_data;
    end
  end

  task automatic drv(input logic cr, input logic cw, input logic [DW-1:0] ca, input logic [DW-1:0] cd,
                     input logic dr, input logic dw, input logic [DW-1:0] da, input logic [DW-1:0] dd);
    bus.cpu_req = cr; bus.cpu_we = cw; bus.cpu_addr = ca; bus.cpu_wdata = cd;
    bus.dma_req = dr; bus.dma_we = dw; bus.dma_addr = da; bus.dma_wdata = dd;
  endtask

  task automatic step(input logic cr, input logic cw, input logic [DW-1:0] ca, input logic [DW-1:0] cd,
                      input logic dr, input logic dw, input logic [DW-1:0] da, input logic [DW-1:0] dd);
    @(posedge clk);
    #1;
    drv(cr, cw, ca, cd, dr, dw, da, dd);
    @(negedge clk);
  endtask

  task automatic idle();
    step(0, 0, '0, '0, 0, 0, '0, '0);
  endtask

  initial begin
    // Reset with a CPU read pending: combinational path live, no rvalid
    drv(1, 0, 24'h000005, '0, 0, 0, '0, '0);
    @(negedge clk);
    chk("rst_mem_re", bus.mem_re, 1);
    chk("rst_stall", bus.cpu_stall, 0);
    @(negedge clk);
    chk("rst_cpu_rvalid", bus.cpu_rvalid, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    drv(0, 0, '0, '0, 0, 0, '0, '0);
    @(negedge clk);
    chk("rel_cpu_rvalid", bus.cpu_rvalid, 0);

    // CPU read of 0x10
    step(1, 0, 24'h000010, '0, 0, 0, '0, '0);
    chk("s1_mem_re", bus.mem_re, 1);
    chk("s1_stall", bus.cpu_stall, 0);
    chk("s1_addr", bus.mem_addr, 24'h000010);
    idle();
    chk("s1_rvalid", bus.cpu_rvalid, 1);
    chk("s1_rdata", bus.cpu_rdata, 24'h5A0010);

    // DMA write 0x00ABCD to 0x200, read back by CPU
    step(0, 0, '0, '0, 1, 1, 24'h000200, 24'h00ABCD);
    chk("s2_gnt", bus.dma_gnt, 1);
    chk("s2_we", bus.mem_we, 1);
    chk("s2_addr", bus.mem_addr, 24'h000200);
    chk("s2_wdata", bus.mem_wdata, 24'h00ABCD);
    step(1, 0, 24'h000200, '0, 0, 0, '0, '0);
    idle();
    chk("s2_readback", bus.cpu_rdata, 24'h00ABCD);

    // Both held: DMA wins at cycles 4 and 9
    for (int k = 0; k < 10; k++) begin
      step(1, 0, 24'h000021, '0, 1, 1, 24'h000300, 24'h111111);
      chk("s3_gnt", bus.dma_gnt, (k == 4 || k == 9));
      chk("s3_stall", bus.cpu_stall, (k == 4 || k == 9));
    end
    idle();

    // CPU read then DMA read: rvalids one cycle apart, rdata gated
    step(1, 0, 24'h000030, '0, 0, 0, '0, '0);
    step(0, 0, '0, '0, 1, 0, 24'h000031, '0);
    chk("s4_cpu_rv", bus.cpu_rvalid, 1);
    chk("s4_dma_rv0", bus.dma_rvalid, 0);
    chk("s4_cpu_rd", bus.cpu_rdata, 24'h5A0030);
    chk("s4_dma_rd0", bus.dma_rdata, 0);
    idle();
    chk("s4_dma_rv", bus.dma_rvalid, 1);
    chk("s4_cpu_rv0", bus.cpu_rvalid, 0);
    chk("s4_dma_rd", bus.dma_rdata, 24'h5A0031);
    chk("s4_cpu_rd0", bus.cpu_rdata, 0);
    idle();
    chk("s4_no_rv", bus.dma_rvalid | bus.cpu_rvalid, 0);

    // CPU write then DMA read of the same address
    step(1, 1, 24'h000040, 24'h123456, 0, 0, '0, '0);
    step(0, 0, '0, '0, 1, 0, 24'h000040, '0);
    idle();
    chk("s5_dma_rv", bus.dma_rvalid, 1);
    chk("s5_dma_rd", bus.dma_rdata, 24'h123456);

    // Reset between a DMA read grant and its return
    step(0, 0, '0, '0, 1, 0, 24'h000050, '0);
    chk("s6_gnt", bus.dma_gnt, 1);
    #2;
    reset = 1'b0;
    drv(0, 0, '0, '0, 0, 0, '0, '0);
    @(negedge clk);
    chk("s6_rst_rv", bus.dma_rvalid, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    chk("s6_rel_rv", bus.dma_rvalid, 0);
    for (int k = 0; k < 5; k++) begin
      step(1, 0, 24'h000060, '0, 1, 1, 24'h000061, 24'h222222);
      chk("s6_gnt_seq", bus.dma_gnt, (k == 4));
    end

    // DMA drops at count 3, then restarts from zero
    for (int k = 0; k < 3; k++) begin
      step(1, 0, 24'h000070, '0, 1, 1, 24'h000071, 24'h333333);
      chk("s7_pre", bus.dma_gnt, 0);
    end
    step(1, 0, 24'h000070, '0, 0, 0, '0, '0);
    chk("s7_drop_stall", bus.cpu_stall, 0);
    for (int k = 0; k < 5; k++) begin
      step(1, 0, 24'h000072, '0, 1, 1, 24'h000073, 24'h444444);
      chk("s7_gnt_seq", bus.dma_gnt, (k == 4));
    end
    idle();
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
